// File: rtl/stb_pkg.sv
// Shared types for the store buffer: entry layout and drain-state encoding.
// No logic; widths here size the interface and the FIFO storage.
package stb_pkg;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTE_SEL_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [BYTE_SEL_WIDTH-1:0] sel_byte;
    logic                      dmem_sel;
  } stb_entry_t;

  typedef enum logic [1:0] {
    DRN_IDLE,
    DRN_SEND,
    DRN_WAIT
  } drain_state_e;
endpackage

// File: rtl/stb_if.sv
// LSU-side store port and dcache-side drain port of the store buffer.
// master = LSU/dcache environment, slave = store buffer.
interface stb_if;
  import stb_pkg::*;

  logic [ADDR_WIDTH-1:0]     lsummu2stb_addr;
  logic [DATA_WIDTH-1:0]     lsummu2stb_wdata;
  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte;
  logic                      lsummu2stb_w_en;
  logic                      lsummu2stb_req;
  logic                      dmem_sel_i;
  logic                      stb2lsummu_stall;
  logic                      stb2lsummu_ack;
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      stb2dcache_w_en;
  logic                      stb2dcache_req;
  logic                      stb2dcache_empty;
  logic                      dmem_sel_o;
  logic                      dcache2stb_ack;

  modport master (
    output lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
           lsummu2stb_w_en, lsummu2stb_req, dmem_sel_i, dcache2stb_ack,
    input  stb2lsummu_stall, stb2lsummu_ack, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel_byte, stb2dcache_w_en, stb2dcache_req,
           stb2dcache_empty, dmem_sel_o
  );

  modport slave (
    input  lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
           lsummu2stb_w_en, lsummu2stb_req, dmem_sel_i, dcache2stb_ack,
    output stb2lsummu_stall, stb2lsummu_ack, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel_byte, stb2dcache_w_en, stb2dcache_req,
           stb2dcache_empty, dmem_sel_o
  );
endinterface

// File: rtl/stb_fifo.sv
// Generic in-order FIFO; write takes effect at the edge, head readable combinationally.
// No internal guard: caller must not push when full or pop when empty.
module stb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/store_buffer_top.sv
// Write-posting store buffer: LSU stores acked combinationally, drained in order to dcache.
// LSU stalls only when full; drain holds each head until dcache ack, then waits for ack release.
module store_buffer_top
  import stb_pkg::*;
#(
  parameter int BLEN = 4
) (
  input logic  clk,
  input logic  rst_n,
  stb_if.slave bus
);
  stb_entry_t   wr_entry;
  stb_entry_t   head;
  logic         full;
  logic         empty;
  logic         store_req;
  logic         push;
  logic         pop;
  drain_state_e state;
  drain_state_e state_nxt;

  assign store_req = bus.lsummu2stb_req & bus.lsummu2stb_w_en;
  // Full check uses the pre-pop occupancy, so a full FIFO never pushes in its pop cycle.
  assign push      = store_req & ~full;
  assign pop       = (state == DRN_SEND) & bus.dcache2stb_ack;

  assign wr_entry.addr     = bus.lsummu2stb_addr;
  assign wr_entry.wdata    = bus.lsummu2stb_wdata;
  assign wr_entry.sel_byte = bus.lsummu2stb_sel_byte;
  assign wr_entry.dmem_sel = bus.dmem_sel_i;

  stb_fifo #(
    .WIDTH ($bits(stb_entry_t)),
    .DEPTH (BLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DRN_IDLE;
    else        state <= state_nxt;
  end

  // WAIT absorbs a long ack level so one ack pulse or level retires a single entry.
  always_comb begin
    state_nxt = state;
    case (state)
      DRN_IDLE: if (!empty)              state_nxt = DRN_SEND;
      DRN_SEND: if (bus.dcache2stb_ack)  state_nxt = DRN_WAIT;
      DRN_WAIT: if (!bus.dcache2stb_ack) state_nxt = DRN_IDLE;
      default:                           state_nxt = DRN_IDLE;
    endcase
  end

  always_comb begin
    bus.stb2lsummu_ack      = push;
    bus.stb2lsummu_stall    = store_req & full;
    bus.stb2dcache_req      = (state == DRN_SEND);
    bus.stb2dcache_w_en     = (state == DRN_SEND);
    bus.stb2dcache_empty    = empty;
    bus.stb2dcache_addr     = empty ? '0 : head.addr;
    bus.stb2dcache_wdata    = empty ? '0 : head.wdata;
    bus.stb2dcache_sel_byte = empty ? '0 : head.sel_byte;
    bus.dmem_sel_o          = (state == DRN_SEND) & head.dmem_sel;
  end
endmodule

// File: tb/tb_store_buffer_top.sv
// Bench for store_buffer_top: directed scenarios then random traffic, scoreboard monitor.
module tb_store_buffer_top;
  import stb_pkg::*;

  localparam int BLEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stb_if bus();

  store_buffer_top #(.BLEN(BLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;
  int pops = 0;
  int resp_mode = 0;  // 0: dcache never acks, 1: ack held 2 cycles, 2: random
  stb_entry_t model_q[$];
  stb_entry_t m_head;
  stb_entry_t m_new;
  logic m_ack;
  logic m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: model of an in-order queue of accepted, not yet retired stores.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_q.delete();
      end else begin
        m_ack   = bus.lsummu2stb_req & bus.lsummu2stb_w_en & (model_q.size() != BLEN);
        m_stall = bus.lsummu2stb_req & bus.lsummu2stb_w_en & (model_q.size() == BLEN);
        m_head  = (model_q.size() != 0) ? model_q[0] : '0;
        chk("lsu_ack", bus.stb2lsummu_ack, m_ack);
        chk("lsu_stall", bus.stb2lsummu_stall, m_stall);
        chk("empty", bus.stb2dcache_empty, model_q.size() == 0);
        chk("dc_addr", bus.stb2dcache_addr, m_head.addr);
        chk("dc_wdata", bus.stb2dcache_wdata, m_head.wdata);
        chk("dc_sel_byte", bus.stb2dcache_sel_byte, m_head.sel_byte);
        chk("dc_w_en", bus.stb2dcache_w_en, bus.stb2dcache_req);
        chk("dmem_sel_o", bus.dmem_sel_o, bus.stb2dcache_req & m_head.dmem_sel);
        if (model_q.size() == 0) chk("dc_req_while_empty", bus.stb2dcache_req, 1'b0);
        if (bus.stb2dcache_req && bus.dcache2stb_ack) begin
          pops++;
          if (model_q.size() != 0) void'(model_q.pop_front());
        end
        if (m_ack) begin
          m_new.addr     = bus.lsummu2stb_addr;
          m_new.wdata    = bus.lsummu2stb_wdata;
          m_new.sel_byte = bus.lsummu2stb_sel_byte;
          m_new.dmem_sel = bus.dmem_sel_i;
          model_q.push_back(m_new);
        end
      end
    end
  end

  // Dcache responder.
  initial begin
    int hold;
    hold = 0;
    bus.dcache2stb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hold = 0;
        bus.dcache2stb_ack = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus.dcache2stb_ack = 1'b0;
      end else if (bus.stb2dcache_req && resp_mode != 0 &&
                   (resp_mode == 1 || $urandom_range(0, 2) == 0)) begin
        bus.dcache2stb_ack = 1'b1;
        hold = (resp_mode == 1) ? 2 : int'($urandom_range(1, 3));
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic ds);
    int n;
    bit got;
    n = 0;
    got = 0;
    bus.lsummu2stb_addr     = a;
    bus.lsummu2stb_wdata    = d;
    bus.lsummu2stb_sel_byte = s;
    bus.dmem_sel_i          = ds;
    bus.lsummu2stb_w_en     = 1'b1;
    bus.lsummu2stb_req      = 1'b1;
    while (!got && n < 400) begin
      @(negedge clk);
      if (bus.stb2lsummu_ack) got = 1;
      n++;
    end
    vecs++;
    if (!got) begin
      errs++;
      $display("FAIL store_accept addr %08h: no ack within %0d cycles, ack required", a, n);
    end
    @(posedge clk);
    #1;
    bus.lsummu2stb_req  = 1'b0;
    bus.lsummu2stb_w_en = 1'b0;
  endtask

  task automatic do_load();
    bus.lsummu2stb_addr  = $urandom;
    bus.lsummu2stb_wdata = $urandom;
    bus.lsummu2stb_w_en  = 1'b0;
    bus.lsummu2stb_req   = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.lsummu2stb_req = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int n;
    n = 0;
    while (!(bus.stb2dcache_empty && model_q.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_completes", bus.stb2dcache_empty, 1'b1);
  endtask

  logic [31:0] dir_addr [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
  logic [31:0] dir_data [4] = '{32'hAAAABBBB, 32'hCCCCDDDD, 32'hBBBBAAAA, 32'hFFFFDDDD};

  initial begin
    int pops0;
    int r;
    bus.lsummu2stb_addr     = '0;
    bus.lsummu2stb_wdata    = '0;
    bus.lsummu2stb_sel_byte = '0;
    bus.lsummu2stb_w_en     = 1'b0;
    bus.lsummu2stb_req      = 1'b0;
    bus.dmem_sel_i          = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_empty", bus.stb2dcache_empty, 1'b1);
    chk("rst_req", bus.stb2dcache_req, 1'b0);
    chk("rst_w_en", bus.stb2dcache_w_en, 1'b0);
    chk("rst_ack", bus.stb2lsummu_ack, 1'b0);
    chk("rst_stall", bus.stb2lsummu_stall, 1'b0);
    chk("rst_addr", bus.stb2dcache_addr, 32'h0);
    chk("rst_wdata", bus.stb2dcache_wdata, 32'h0);
    chk("rst_sel", bus.stb2dcache_sel_byte, 4'h0);
    chk("rst_dmem_sel", bus.dmem_sel_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill with dcache silent
    resp_mode = 0;
    for (int i = 0; i < 4; i++) do_store(dir_addr[i], dir_data[i], 4'hF, i[0]);

    // Fifth store while full: stalls until the first entry retires
    fork
      do_store(32'h2000, 32'h12345678, 4'hF, 1'b1);
      begin
        repeat (3) @(negedge clk);
        chk("full_stall", bus.stb2lsummu_stall, 1'b1);
        chk("full_no_ack", bus.stb2lsummu_ack, 1'b0);
        resp_mode = 1;
      end
    join
    wait_empty(200);
    chk("drained_count", pops, 5);

    // Push and pop in the same cycle at two entries
    resp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    do_store(32'h3000, 32'h0BADF00D, 4'h3, 1'b0);
    do_store(32'h3004, 32'hDEADBEEF, 4'hC, 1'b1);
    @(posedge clk);
    #3;
    resp_mode = 1;
    @(posedge clk);
    #2;
    do_store(32'h3008, 32'hCAFEF00D, 4'hF, 1'b1);
    pops0 = pops;
    wait_empty(200);
    chk("pops_after_simul", pops - pops0, 2);

    // Reset while a drain request is outstanding
    resp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    do_store(32'h4000, 32'h11112222, 4'hF, 1'b1);
    do_store(32'h4004, 32'h33334444, 4'hF, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_req", bus.stb2dcache_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.stb2dcache_req, 1'b0);
    chk("mid_rst_empty", bus.stb2dcache_empty, 1'b1);
    chk("mid_rst_dmem_sel", bus.dmem_sel_o, 1'b0);
    chk("mid_rst_addr", bus.stb2dcache_addr, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    resp_mode = 2;
    repeat (300) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) do_load();
      else if (r < 3) begin
        @(posedge clk);
        #1;
      end else do_store($urandom, $urandom, 4'($urandom), 1'($urandom));
    end
    wait_empty(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
